lock_display_driver: RTL

//  Downstream stage of the password-lock System: consumes its state, code, entry count, error count and ID flag.

---
 rtl/lock_display_driver.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lock_display_driver.sv
// -----------------------------------------------------------------------------
// lock_display_driver
//
// Display back end of the password lock. Takes the lock's state, entered code,
// digit count, failed-attempt count and ID flag, and drives an 8-digit
// multiplexed 7-segment display and 16 status LEDs. All outputs are registered.
//
// Parameters
//   SCAN_DIV   CLK cycles each digit stays enabled (>= 2)
//   BLINK_DIV  CLK cycles per blink half-period (>= 2)
//
// Ports
//   CLK         system clock, rising edge
//   RESET       synchronous, active-high
//   STATE[2:0]  0 WAIT, 1 INPUT, 2 ERROR, 3 ALARM, 4 UNLOCK, 5-7 invalid
//   CODE[15:0]  entered code, CODE[15:12] is the first digit entered
//   CODE_BIT    digits entered so far (values above 4 count as 4)
//   ERROR_TIME  failed attempts so far
//   ID_FLAG     1 = admin, 0 = user
//   AN[7:0]     digit enables, active-low, AN[0] = rightmost digit
//   SEG[7:0]    segments, active-low, SEG[6:0] = g..a, SEG[7] = dp
//   LD[15:0]    status LEDs, active-high
// -----------------------------------------------------------------------------
module lock_display_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  STATE,
  input  logic [15:0] CODE,
  input  logic [2:0]  CODE_BIT,
  input  logic [1:0]  ERROR_TIME,
  input  logic        ID_FLAG,
  output logic [7:0]  AN,
  output logic [7:0]  SEG,
  output logic [15:0] LD
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_INPUT  = 3'd1,
    ST_ERROR  = 3'd2,
    ST_ALARM  = 3'd3,
    ST_UNLOCK = 3'd4
  } lock_state_e;

  // Active-high a..g glyphs (bit 7 = dp)
  localparam logic [7:0] G_BLANK = 8'h00;
  localparam logic [7:0] G_DASH  = 8'h40;
  localparam logic [7:0] G_UNDER = 8'h08;
  localparam logic [7:0] G_R     = 8'h50;
  localparam logic [7:0] G_P     = 8'h73;
  localparam logic [7:0] G_N     = 8'h54;
  localparam logic [7:0] G_U     = 8'h3E;
  localparam logic [7:0] G_A     = 8'h77;
  localparam logic [7:0] G_E     = 8'h79;
  localparam logic [7:0] G_ZERO  = 8'h3F;
  localparam logic [7:0] G_ALL   = 8'hFF;

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'h3F;  4'h1: g = 8'h06;  4'h2: g = 8'h5B;  4'h3: g = 8'h4F;
      4'h4: g = 8'h66;  4'h5: g = 8'h6D;  4'h6: g = 8'h7D;  4'h7: g = 8'h07;
      4'h8: g = 8'h7F;  4'h9: g = 8'h6F;  4'hA: g = 8'h77;  4'hB: g = 8'h7C;
      4'hC: g = 8'h39;  4'hD: g = 8'h5E;  4'hE: g = 8'h79;  default: g = 8'h71;
    endcase
    return g;
  endfunction

  function automatic logic [2:0] clamp_count(input logic [2:0] cb);
    return (cb > 3'd4) ? 3'd4 : cb;
  endfunction

  // Glyph for one digit position; cb is already clamped to 0..4.
  function automatic logic [7:0] digit_glyph(
    input logic [2:0]  idx,
    input logic [2:0]  st,
    input logic [15:0] code,
    input logic [2:0]  cb,
    input logic [1:0]  et,
    input logic        id,
    input logic        blink
  );
    logic [7:0] g;
    logic [3:0] nib;
    g   = G_BLANK;
    nib = 4'(code >> {idx, 2'b00});
    case (st)
      ST_WAIT:   g = (idx < 3'd4) ? G_DASH : G_BLANK;
      ST_INPUT: begin
        case (idx)
          3'd7:       g = id ? G_A : G_U;
          3'd5:       g = hex_glyph({2'b00, et});
          3'd6, 3'd4: g = G_BLANK;
          // Digit idx shows nibble idx; it is filled once the entry count
          // reaches it from the left (d3 first), otherwise shows '_'.
          default:    g = (({1'b0, idx} + {1'b0, cb}) >= 4'd4) ? hex_glyph(nib) : G_UNDER;
        endcase
      end
      ST_ERROR: begin
        if (blink) begin
          case (idx)
            3'd7:       g = G_E;
            3'd6, 3'd5: g = G_R;
            3'd4:       g = hex_glyph({2'b00, et});
            default:    g = G_BLANK;
          endcase
        end
      end
      ST_ALARM:  g = blink ? G_ALL : G_BLANK;
      ST_UNLOCK: begin
        case (idx)
          3'd3:    g = G_ZERO;
          3'd2:    g = G_P;
          3'd1:    g = G_E;
          3'd0:    g = G_N;
          default: g = G_BLANK;
        endcase
      end
      default:   g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [15:0] status_leds(
    input logic [2:0] st,
    input logic [2:0] cb,
    input logic [1:0] et,
    input logic       id,
    input logic       blink
  );
    logic [15:0] v;
    logic        alarm_on;
    v        = '0;
    alarm_on = (st == ST_ALARM) && blink;
    if (st <= ST_UNLOCK) begin
      v[3:0]  = 4'((5'd1 << cb) - 5'd1);
      v[5:4]  = et;
      v[11:6] = {6{alarm_on}};
      v[13]   = id;
      v[14]   = (st == ST_UNLOCK);
      v[15]   = alarm_on;
    end
    return v;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         digit_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [2:0]         state_p1;

  logic               state_chg;
  logic [BLINK_W-1:0] blink_cnt_eff;
  logic               blink_on_eff;
  logic [2:0]         cb_clamp;

  // A state change restarts the blink phase in the same cycle, so the first
  // half-period of a new ERROR/ALARM is visible and lasts the full BLINK_DIV.
  always_comb begin
    state_chg     = (STATE != state_p1);
    blink_cnt_eff = state_chg ? '0 : blink_cnt;
    blink_on_eff  = state_chg | blink_on;
    cb_clamp      = clamp_count(CODE_BIT);
  end

  // Previous-cycle STATE, used only for change detection
  always_ff @(posedge CLK) begin
    state_p1 <= STATE;
  end

  // Counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt  <= '0;
      digit_idx <= 3'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      AN        <= 8'hFF;
      SEG       <= 8'hFF;
      LD        <= 16'h0000;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt  <= scan_cnt + SCAN_W'(1);
      end

      if (blink_cnt_eff == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on_eff;
      end else begin
        blink_cnt <= blink_cnt_eff + BLINK_W'(1);
        blink_on  <= blink_on_eff;
      end

      AN  <= ~(8'h01 << digit_idx);
      SEG <= ~digit_glyph(digit_idx, STATE, CODE, cb_clamp, ERROR_TIME, ID_FLAG, blink_on_eff);
      LD  <= status_leds(STATE, cb_clamp, ERROR_TIME, ID_FLAG, blink_on_eff);
    end
  end

endmodule
